// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with a combinational hit path and a
// req/ack line-fill engine that refills one line per miss.
module icache_fetch #(
  parameter int ADDR_WIDTH = 14,
  parameter int LINES      = 16,
  parameter int WORDS      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  invalidate,
  output logic [31:0]           dout,
  output logic                  valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q;
  logic [OFF_W-1:0]  beat_q;
  logic [TAG_W-1:0]  ftag_q;
  logic [IDX_W-1:0]  fidx_q;
  logic [LINES-1:0]  vld_q;
  logic              supp_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;

  logic [31:0]       data_q [LINES][WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              fill_beat;
  logic              last_beat;

  assign off = addr[OFF_W-1:0];
  assign idx = addr[OFF_W +: IDX_W];
  assign tag = addr[ADDR_WIDTH-1 -: TAG_W];

  assign hit       = rden && (state_q == IDLE) && vld_q[idx] && (tag_q[idx] == tag);
  assign fill_beat = (state_q == FILL) && mem_ack;
  assign last_beat = fill_beat && (beat_q == BEAT_LAST);

  assign valid      = hit;
  assign dout       = hit ? data_q[idx][off] : 32'h0;
  assign mem_req    = (state_q == FILL);
  assign mem_addr   = (state_q == FILL) ? {ftag_q, fidx_q, beat_q} : '0;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Storage arrays carry no reset; the valid vector alone decides what is live.
  always_ff @(posedge CLK) begin
    if (fill_beat) begin
      data_q[fidx_q][beat_q] <= mem_rdata;
      if (last_beat) tag_q[fidx_q] <= ftag_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      ftag_q     <= '0;
      fidx_q     <= '0;
      vld_q      <= '0;
      supp_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
          if (invalidate) vld_q <= '0;
          if (rden && !hit) begin
            // Old contents of the victim line stop being valid as soon as it is overwritten.
            vld_q[idx] <= 1'b0;
            state_q    <= FILL;
            ftag_q     <= tag;
            fidx_q     <= idx;
            beat_q     <= '0;
            supp_q     <= invalidate;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
          end
        end
        FILL: begin
          if (invalidate) begin
            vld_q  <= '0;
            supp_q <= 1'b1;
          end
          if (mem_ack) begin
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == BEAT_LAST) begin
              // A flush seen at any point of the fill, including this beat, keeps the line dead.
              if (!supp_q && !invalidate) vld_q[fidx_q] <= 1'b1;
              supp_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: line-level reference model compared every
// cycle, directed scenarios pinned with literal values, then randomized traffic.
module tb_icache_fetch;
  localparam int AW    = 14;
  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic          CLK = 1'b0;
  logic          RESET, rden, invalidate, mem_ack;
  logic [AW-1:0] addr, mem_addr;
  logic [31:0]   mem_rdata, dout;
  logic          valid, mem_req;
  logic [15:0]   hit_count, miss_count;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  started = 1'b0;
  bit  simple;
  int  ackmode;
  int  cyc;

  always #5 CLK = ~CLK;

  icache_fetch #(.ADDR_WIDTH(AW), .LINES(LINES), .WORDS(WORDS)) dut (
    .CLK(CLK), .RESET(RESET), .rden(rden), .addr(addr), .invalidate(invalidate),
    .dout(dout), .valid(valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Reference model: each line remembers the base word address it holds (-1 = nothing).
  int          m_base [LINES];
  logic [31:0] m_data [LINES][WORDS];
  bit          m_fill, m_supp;
  int          m_fbase, m_beat, m_hits, m_miss;

  function automatic int lidx(int a);
    return (a / WORDS) % LINES;
  endfunction

  function automatic int lbase(int a);
    return a - (a % WORDS);
  endfunction

  logic          e_hit;
  logic [31:0]   e_dout;
  logic [AW-1:0] e_maddr;
  int            ca;

  always_comb begin
    ca      = int'(addr);
    e_hit   = rden && !m_fill && (m_base[lidx(ca)] == lbase(ca));
    e_dout  = e_hit ? m_data[lidx(ca)][ca % WORDS] : 32'h0;
    e_maddr = m_fill ? AW'(m_fbase + m_beat) : '0;
  end

  assign mem_rdata = simple ? (32'hA0 + 32'(m_beat))
                            : (32'h9E3779B9 * (32'(e_maddr) + 32'd1));

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < LINES; i++) m_base[i] <= -1;
      m_fill <= 1'b0; m_supp <= 1'b0; m_fbase <= 0; m_beat <= 0;
      m_hits <= 0;    m_miss <= 0;
    end else if (!m_fill) begin
      if (e_hit) m_hits <= (m_hits < 65535) ? m_hits + 1 : 65535;
      if (invalidate) for (int i = 0; i < LINES; i++) m_base[i] <= -1;
      if (rden && !e_hit) begin
        m_base[lidx(int'(addr))] <= -1;
        m_fill  <= 1'b1;
        m_fbase <= lbase(int'(addr));
        m_beat  <= 0;
        m_supp  <= invalidate;
        m_miss  <= (m_miss < 65535) ? m_miss + 1 : 65535;
      end
    end else begin
      if (invalidate) begin
        for (int i = 0; i < LINES; i++) m_base[i] <= -1;
        m_supp <= 1'b1;
      end
      if (mem_ack) begin
        m_data[lidx(m_fbase)][m_beat] <= mem_rdata;
        if (m_beat == WORDS - 1) begin
          if (!m_supp && !invalidate) m_base[lidx(m_fbase)] <= m_fbase;
          m_fill <= 1'b0; m_beat <= 0; m_supp <= 1'b0;
        end else begin
          m_beat <= m_beat + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (started) begin
      check("valid",      32'(valid),      32'(e_hit));
      check("dout",       dout,            e_dout);
      check("mem_req",    32'(mem_req),    32'(m_fill));
      check("mem_addr",   32'(mem_addr),   32'(e_maddr));
      check("hit_count",  32'(hit_count),  32'(m_hits));
      check("miss_count", 32'(miss_count), 32'(m_miss));
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
    cyc++;
    case (ackmode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (cyc % 3 == 0);
      default: mem_ack = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic wait_hit(input string nm, input int budget);
    int k;
    k = 0;
    #1;
    while (!valid && k < budget) begin
      nxt();
      k++;
    end
    check(nm, 32'(valid), 32'd1);
  endtask

  initial begin
    RESET = 1'b0; rden = 1'b0; addr = '0; invalidate = 1'b0; mem_ack = 1'b0;
    simple = 1'b1; ackmode = 0; cyc = 0;
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    started = 1'b1;
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_req",   32'(mem_req), 0);
    check("rst_dout",  dout, 0);
    check("rst_hits",  32'(hit_count), 0);

    // Cold miss on 0x42, memory answers every cycle
    rden = 1'b1; addr = 14'h042; mem_ack = 1'b1;
    #1;
    check("c0_valid", 32'(valid), 0);
    for (int b = 0; b < 4; b++) begin
      nxt();
      check("fill_req",  32'(mem_req), 1);
      check("fill_addr", 32'(mem_addr), 32'h40 + 32'(b));
      check("fill_valid", 32'(valid), 0);
    end
    nxt();
    check("c5_valid", 32'(valid), 1);
    check("c5_dout",  dout, 32'hA2);
    check("c5_miss",  32'(miss_count), 1);

    // Hit streak across the whole line
    for (int i = 0; i < 4; i++) begin
      addr = AW'(32'h40 + 32'(i));
      #1;
      check("streak_valid", 32'(valid), 1);
      check("streak_dout",  dout, 32'hA0 + 32'(i));
      check("streak_req",   32'(mem_req), 0);
      nxt();
    end
    check("streak_hits", 32'(hit_count), 4);

    // Conflict on index 0 with slow memory, then the old line misses again
    ackmode = 1;
    addr = 14'h082;
    #1;
    check("conf_miss", 32'(valid), 0);
    nxt();
    check("conf_req", 32'(mem_req), 1);
    check("conf_addr", 32'(mem_addr), 32'h80);
    wait_hit("conf_fill", 60);
    check("conf_dout", dout, 32'hA2);
    addr = 14'h042;
    #1;
    check("re_miss", 32'(valid), 0);
    wait_hit("refill42", 60);
    check("miss3", 32'(miss_count), 3);

    // Flush in the middle of a fill
    ackmode = 0; mem_ack = 1'b1;
    addr = 14'h010;
    #1;
    check("inv_c0", 32'(valid), 0);
    nxt(); nxt();
    invalidate = 1'b1;
    nxt();
    invalidate = 1'b0;
    nxt(); nxt();
    #1;
    check("inv_idle", 32'(mem_req), 0);
    check("inv_miss", 32'(valid), 0);
    wait_hit("inv_refill", 20);
    addr = 14'h042;
    #1;
    check("old_line_miss", 32'(valid), 0);
    wait_hit("refill42b", 20);

    // Asynchronous reset during beat 1
    addr = 14'h0C4;
    #1;
    check("rstf_c0", 32'(valid), 0);
    nxt(); nxt();
    #2 RESET = 1'b1;
    #1;
    check("rstf_req",   32'(mem_req), 0);
    check("rstf_valid", 32'(valid), 0);
    check("rstf_hits",  32'(hit_count), 0);
    check("rstf_miss",  32'(miss_count), 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    addr = 14'h042;
    #1;
    check("post_rst_miss", 32'(valid), 0);
    check("post_rst_hits", 32'(hit_count), 0);
    wait_hit("post_rst_fill", 20);

    // Randomized traffic with random memory latency, flushes and resets
    simple = 1'b0; ackmode = 2;
    repeat (3000) begin
      nxt();
      rden       = ($urandom_range(0, 9) != 0);
      addr       = AW'($urandom_range(0, 3) * LINES * WORDS + $urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) addr = AW'($urandom);
      invalidate = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1 RESET = 1'b1;
        #1 RESET = 1'b0;
      end
    end

    // Hit counter saturation
    ackmode = 0; invalidate = 1'b0; rden = 1'b1; addr = 14'h042;
    wait_hit("sat_fill", 60);
    repeat (65540) nxt();
    check("hit_sat", 32'(hit_count), 32'hFFFF);
    nxt();
    check("hit_sat_hold", 32'(hit_count), 32'hFFFF);
    rden = 1'b0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC and the backing program memory.
- It returns the instruction word for a word address. It raises `valid` on a hit.
- On a miss it runs a line-fill state machine over a req/ack bus, then serves the word.
- `valid` is the fetch-side memory-valid signal the hazard unit uses to stall fetch and decode while a fill is in progress.

Parameters:
- ADDR_WIDTH, 14, word-address width (PC[15:2]).
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, words per line; power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- rden  in  1  fetch read request; lookups happen only when this is 1.
- addr  in  ADDR_WIDTH  word address of the instruction.
- invalidate  in  1  one-cycle pulse that clears all valid bits (fence.i / flush).
- dout  out  32  instruction word; 0 when not a hit.
- valid  out  1  1 when rden=1 and addr hits a valid line in IDLE.
- mem_req  out  1  fill request to backing memory.
- mem_addr  out  ADDR_WIDTH  word address of the current fill beat.
- mem_ack  in  1  backing memory has returned mem_rdata this cycle.
- mem_rdata  in  32  fill data, sampled when mem_req & mem_ack.
- hit_count  out  16  hits counted while rden=1; saturates at 16'hFFFF.
- miss_count  out  16  misses counted (one per fill start); saturates.

Behaviour:
- Address split: offset = addr[log2(WORDS)-1:0]; index = next log2(LINES) bits; tag = remaining upper bits. Defaults: offset [1:0], index [5:2], tag [13:6].
- Storage: data array LINES×WORDS×32, tag array, and a LINES-bit valid vector. Arrays are not reset; only the valid vector is.
- Hit path is combinational (zero latency): hit = rden & state==IDLE & valid_bit[index] & tag_arr[index]==tag.
  - valid = hit. dout = data[index][offset] if hit, else 32'h0.
- FSM states: IDLE and FILL.
  - IDLE → FILL on a rising edge where rden=1 and there is no hit (the miss).
    - Latch fill_tag and fill_index from addr.
    - Set beat counter = 0.
    - Increment miss_count.
  - FILL behaviour:
    - mem_req=1 and mem_addr={fill_tag, fill_index, beat}.
    - On each edge with mem_ack=1: write mem_rdata into data[fill_index][beat], then beat++.
    - mem_req stays high across beats; mem_addr is stable until acked.
    - On the ack of beat WORDS-1: write tag_arr[fill_index]=fill_tag, set valid_bit[fill_index]=1 (unless suppressed, see below), beat wraps to 0, go to IDLE.
  - In IDLE: mem_req=0 and mem_addr=0.
- Timing with mem_ack tied high, WORDS=4: miss seen in cycle 0; FILL in cycles 1–4; first hit possible in cycle 5. valid=0 in cycles 0–4.
- addr and rden may change during FILL. The fill always completes for the latched line. valid stays 0 throughout FILL.
- A fill overwrites the line unconditionally; there is no write-back (read-only cache). The old valid bit for fill_index is cleared when FILL is entered.
- invalidate:
  - In IDLE: all valid bits clear on the next edge. A hit in that same cycle is still reported.
  - In FILL: all valid bits clear immediately, and a suppress flag is set. The fill completes, but its line is not marked valid. The flag clears on return to IDLE.
  - invalidate coincident with a miss edge: the valid bits clear, the fill starts, and the fill is suppressed.
- Counters:
  - hit_count increments on each edge where valid=1.
  - miss_count increments on each IDLE→FILL transition.
  - Both saturate at 16'hFFFF. Neither is cleared by invalidate.
- Reset (async, any time, including mid-FILL):
  - state=IDLE, beat=0, all valid bits 0, suppress=0, counters 0.
  - mem_req=0, mem_addr=0, valid=0, dout=0.
  - A fill in flight is abandoned; the backing memory must tolerate mem_req dropping.

Test Plan:
- Cold miss: reset; rden=1, addr=0x0042; mem_ack high, mem_rdata = 0xA0+beat. Expect mem_addr 0x40,0x41,0x42,0x43 in cycles 1–4; valid=1 and dout=0xA2 in cycle 5; miss_count=1.
- Hit streak: after the fill above, step addr 0x40..0x43 across 4 cycles. Expect valid=1 every cycle, dout 0xA0..0xA3, hit_count +4, mem_req=0.
- Conflict and slow memory: addr=0x0082 (same index 0, tag 2), mem_ack high only every 3rd cycle. Expect mem_req held with stable mem_addr between acks and line refilled; then addr=0x0042 misses again; miss_count=3.
- Invalidate mid-fill: pulse invalidate in cycle 2 of a fill for addr 0x0010. Expect fill completes (4 beats), next lookup of 0x0010 misses; old line 0x0040 also misses.
- Reset mid-fill: assert RESET during beat 1. Expect mem_req=0 and valid=0 immediately (asynchronous); after release, addr=0x0042 misses and counters read 0.
- Saturation: force 65 540 hits. Expect hit_count stays at 0xFFFF and does not wrap.
